// File: rtl/dma_mc.sv
// Round-robin multi-channel DMA front end: one read or write burst in flight, fed through the AXI master FIFOs.
// Optional no-progress timeout enabled by defining DMA_MC_TIMEOUT_EN.
module dma_mc #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int LEN_WIDTH      = 8,
  parameter int NUM_CH         = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                           cpu_clk,
  input  logic                           cpu_rst_n,
  input  logic [NUM_CH-1:0]              ch_req_valid,
  input  logic [NUM_CH-1:0]              ch_req_write,
  input  logic [NUM_CH*ADDR_WIDTH-1:0]   ch_req_addr,
  input  logic [NUM_CH*LEN_WIDTH-1:0]    ch_req_len,
  output logic [NUM_CH-1:0]              ch_req_done,
  output logic [NUM_CH-1:0]              ch_req_err,
  output logic [NUM_CH-1:0]              ch_rvalid,
  output logic [DATA_WIDTH-1:0]          ch_rdata,
  output logic [NUM_CH-1:0]              ch_wpull,
  input  logic [NUM_CH*DATA_WIDTH-1:0]   ch_wdata,
  output logic                           axi_master_read_start,
  input  logic                           axi_master_read_done,
  output logic [ADDR_WIDTH-1:0]          axi_master_target_read_addr,
  output logic [LEN_WIDTH-1:0]           axi_master_target_read_burst_len,
  output logic                           master2dma_afifo_rpull,
  input  logic                           master2dma_afifo_rempty,
  input  logic [DATA_WIDTH-1:0]          master2dma_afifo_rdata,
  output logic                           axi_master_write_start,
  input  logic                           axi_master_write_done,
  output logic [ADDR_WIDTH-1:0]          axi_master_target_write_addr,
  output logic [LEN_WIDTH-1:0]           axi_master_target_write_burst_len,
  output logic                           dma2master_afifo_wpush,
  output logic [DATA_WIDTH-1:0]          dma2master_afifo_wdata,
  input  logic                           dma2master_afifo_wfull
);

  localparam int GW = $clog2(NUM_CH);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t                state;
  logic [GW-1:0]         grant, last_grant, next_grant, cand;
  logic                  any_req;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [LEN_WIDTH:0]    cnt, cnt_next, beats;
  logic                  done_seen, done_pulse, xfer_done, beat;
  logic [NUM_CH-1:0]     grant_oh;

  logic [ADDR_WIDTH-1:0] addr_arr  [NUM_CH];
  logic [LEN_WIDTH-1:0]  len_arr   [NUM_CH];
  logic [DATA_WIDTH-1:0] wdata_arr [NUM_CH];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
    assign addr_arr[g]  = ch_req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign len_arr[g]   = ch_req_len[g*LEN_WIDTH +: LEN_WIDTH];
    assign wdata_arr[g] = ch_wdata[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // Scan from farthest to nearest so the first requester after last_grant is the final winner.
  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    next_grant = last_grant;
    any_req    = 1'b0;
    cand       = '0;
    for (int i = NUM_CH; i >= 1; i--) begin
      cand = GW'((int'(last_grant) + i) % NUM_CH);
      if (ch_req_valid[cand]) begin
        next_grant = cand;
        any_req    = 1'b1;
      end
    end
  end

  // Counter is one bit wider than len so len+1 beats never wraps.
  assign beats      = {1'b0, len_q} + {{LEN_WIDTH{1'b0}}, 1'b1};
  assign grant_oh   = NUM_CH'(1) << grant;
  assign done_pulse = (state == RD) ? axi_master_read_done : axi_master_write_done;
  assign xfer_done  = done_seen | done_pulse;

  assign master2dma_afifo_rpull = (state == RD) && !master2dma_afifo_rempty && (cnt < beats);
  assign dma2master_afifo_wpush = (state == WR) && !dma2master_afifo_wfull && (cnt < beats);
  assign beat     = master2dma_afifo_rpull | dma2master_afifo_wpush;
  assign cnt_next = cnt + {{LEN_WIDTH{1'b0}}, beat};

`ifdef DMA_MC_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo;
  logic          err_q;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= GW'(NUM_CH - 1);
      addr_q     <= '0;
      len_q      <= '0;
      cnt        <= '0;
      done_seen  <= 1'b0;
`ifdef DMA_MC_TIMEOUT_EN
      tmo        <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (any_req) begin
          grant      <= next_grant;
          last_grant <= next_grant;
          addr_q     <= addr_arr[next_grant];
          len_q      <= len_arr[next_grant];
          cnt        <= '0;
          done_seen  <= 1'b0;
`ifdef DMA_MC_TIMEOUT_EN
          tmo        <= '0;
          err_q      <= 1'b0;
`endif
          state      <= ch_req_write[next_grant] ? WR : RD;
        end
        RD, WR: begin
          cnt       <= cnt_next;
          done_seen <= xfer_done;
          if (xfer_done && (cnt_next == beats)) begin
            state <= DONE;
          end
`ifdef DMA_MC_TIMEOUT_EN
          else if (!beat && !done_pulse) begin
            if (tmo == TW'(TIMEOUT_CYCLES - 1)) begin
              state <= DONE;
              err_q <= 1'b1;
            end else begin
              tmo <= tmo + 1'b1;
            end
          end else begin
            tmo <= '0;
          end
`endif
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign ch_req_done = (state == DONE) ? grant_oh : '0;
`ifdef DMA_MC_TIMEOUT_EN
  assign ch_req_err  = (state == DONE && err_q) ? grant_oh : '0;
`else
  assign ch_req_err  = '0;
`endif

  assign ch_rvalid = master2dma_afifo_rpull ? grant_oh : '0;
  assign ch_rdata  = master2dma_afifo_rpull ? master2dma_afifo_rdata : '0;
  assign ch_wpull  = dma2master_afifo_wpush ? grant_oh : '0;
  assign dma2master_afifo_wdata = dma2master_afifo_wpush ? wdata_arr[grant] : '0;

  assign axi_master_read_start             = (state == RD);
  assign axi_master_target_read_addr       = (state == RD) ? addr_q : '0;
  assign axi_master_target_read_burst_len  = (state == RD) ? len_q : '0;
  assign axi_master_write_start            = (state == WR);
  assign axi_master_target_write_addr      = (state == WR) ? addr_q : '0;
  assign axi_master_target_write_burst_len = (state == WR) ? len_q : '0;

endmodule

// File: tb/tb_dma_mc.sv
// Directed self-checking bench for dma_mc; the timeout scenario follows DMA_MC_TIMEOUT_EN.
module tb_dma_mc;
  localparam int AW = 32, DW = 32, LW = 8, NC = 4;

  logic              cpu_clk = 1'b0;
  logic              cpu_rst_n = 1'b0;
  logic [NC-1:0]     ch_req_valid, ch_req_write;
  logic [NC*AW-1:0]  ch_req_addr;
  logic [NC*LW-1:0]  ch_req_len;
  logic [NC-1:0]     ch_req_done, ch_req_err, ch_rvalid, ch_wpull;
  logic [DW-1:0]     ch_rdata;
  logic [NC*DW-1:0]  ch_wdata;
  logic              read_start, read_done, rpull, rempty;
  logic [AW-1:0]     read_addr, write_addr;
  logic [LW-1:0]     read_len, write_len;
  logic [DW-1:0]     rdata, wdata;
  logic              write_start, write_done, wpush, wfull;

  int checks = 0;
  int failures = 0;
  int n, idx, rbeat;
  logic stall, full;

  dma_mc #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW), .NUM_CH(NC), .TIMEOUT_CYCLES(1024)) dut (
    .cpu_clk(cpu_clk), .cpu_rst_n(cpu_rst_n),
    .ch_req_valid(ch_req_valid), .ch_req_write(ch_req_write),
    .ch_req_addr(ch_req_addr), .ch_req_len(ch_req_len),
    .ch_req_done(ch_req_done), .ch_req_err(ch_req_err),
    .ch_rvalid(ch_rvalid), .ch_rdata(ch_rdata), .ch_wpull(ch_wpull), .ch_wdata(ch_wdata),
    .axi_master_read_start(read_start), .axi_master_read_done(read_done),
    .axi_master_target_read_addr(read_addr), .axi_master_target_read_burst_len(read_len),
    .master2dma_afifo_rpull(rpull), .master2dma_afifo_rempty(rempty), .master2dma_afifo_rdata(rdata),
    .axi_master_write_start(write_start), .axi_master_write_done(write_done),
    .axi_master_target_write_addr(write_addr), .axi_master_target_write_burst_len(write_len),
    .dma2master_afifo_wpush(wpush), .dma2master_afifo_wdata(wdata), .dma2master_afifo_wfull(wfull)
  );

  always #5 cpu_clk = ~cpu_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic set_req(input int ch, input logic wr, input logic [AW-1:0] addr, input logic [LW-1:0] len);
    ch_req_valid[ch] = 1'b1;
    ch_req_write[ch] = wr;
    ch_req_addr[ch*AW +: AW] = addr;
    ch_req_len[ch*LW +: LW] = len;
  endtask

  // Single-beat read with done arriving with the beat; starts in an IDLE cycle, ends in the next IDLE cycle.
  task automatic run_len0_read(input int ch, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    tick();
    check("rr_rd_start", read_start, 1);
    check("rr_rd_addr", read_addr, addr);
    rempty = 1'b0; rdata = data; read_done = 1'b1;
    #1;
    check("rr_rvalid", ch_rvalid, 64'(1) << ch);
    check("rr_rdata", ch_rdata, data);
    tick();
    rempty = 1'b1; read_done = 1'b0;
    #1;
    check("rr_done", ch_req_done, 64'(1) << ch);
    tick();
    check("rr_done_clear", ch_req_done, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, |{ch_req_done, ch_req_err, ch_rvalid, ch_rdata, ch_wpull, read_start, read_addr,
                 read_len, rpull, write_start, write_addr, write_len, wpush, wdata}, 0);
  endtask

  initial begin
    ch_req_valid = '0; ch_req_write = '0; ch_req_addr = '0; ch_req_len = '0; ch_wdata = '0;
    read_done = 1'b0; write_done = 1'b0; rempty = 1'b1; rdata = '0; wfull = 1'b0;

    // Reset state
    repeat (2) @(posedge cpu_clk);
    #1;
    check_all_zero("reset_outputs");

    // Ch0 and ch2 together after reset: ch0, ch2, ch0, ch2
    set_req(0, 1'b0, 32'h100, 8'd0);
    set_req(2, 1'b0, 32'h200, 8'd0);
    @(negedge cpu_clk) cpu_rst_n = 1'b1;
    run_len0_read(0, 32'h100, 32'h11);
    run_len0_read(2, 32'h200, 32'h22);
    run_len0_read(0, 32'h100, 32'h33);
    run_len0_read(2, 32'h200, 32'h44);
    ch_req_valid = '0;

    // Ch1 read len 7 with two FIFO stalls, done at beat 4, valid dropped mid-burst
    set_req(1, 1'b0, 32'h1000, 8'd7);
    tick();
    check("r7_start", read_start, 1);
    check("r7_addr", read_addr, 32'h1000);
    check("r7_len", read_len, 7);
    check("r7_no_wstart", write_start, 0);
    rbeat = 0;
    for (int c = 0; c < 10; c++) begin
      stall = (c == 2 || c == 5);
      rempty = stall;
      rdata = 32'hA0 + rbeat;
      read_done = (rbeat == 3 && !stall);
      if (c == 4) ch_req_valid[1] = 1'b0;
      #1;
      check("r7_no_early_done", ch_req_done, 0);
      if (stall) begin
        check("r7_stall_rvalid", ch_rvalid, 0);
      end else begin
        check("r7_rvalid", ch_rvalid, 4'b0010);
        check("r7_rdata", ch_rdata, 32'hA0 + rbeat);
        rbeat++;
      end
      tick();
    end
    rempty = 1'b1; read_done = 1'b0;
    #1;
    check("r7_done", ch_req_done, 4'b0010);
    check("r7_err", ch_req_err, 0);
    tick();
    check("r7_done_one_cycle", ch_req_done, 0);

    // Ch2 read len 255, done before any beat: exactly 256 pulls
    set_req(2, 1'b0, 32'h2000, 8'd255);
    tick();
    check("r255_len", read_len, 8'hFF);
    read_done = 1'b1;
    #1;
    check("r255_no_pull_empty", rpull, 0);
    tick();
    read_done = 1'b0; rempty = 1'b0; n = 0;
    for (int i = 0; i < 256; i++) begin
      rdata = i;
      #1;
      if (rpull) n++;
      tick();
    end
    check("r255_pulls", n, 256);
    check("r255_no_257th", rpull, 0);
    check("r255_done", ch_req_done, 4'b0100);
    ch_req_valid[2] = 1'b0;
    tick();
    check("r255_idle_no_pull", rpull, 0);
    rempty = 1'b1;

    // Ch3 write len 3 with wfull for 5 cycles, write_done while full
    set_req(3, 1'b1, 32'h3000, 8'd3);
    tick();
    check("w3_start", write_start, 1);
    check("w3_addr", write_addr, 32'h3000);
    check("w3_len", write_len, 3);
    check("w3_read_addr_zero", read_addr, 0);
    idx = 0; n = 0;
    for (int c = 0; c < 9; c++) begin
      full = (c >= 2 && c <= 6);
      wfull = full;
      write_done = (c == 4);
      ch_wdata[3*DW +: DW] = 32'hC0DE_0000 + idx;
      #1;
      check("w3_push", wpush, !full);
      if (wpush) n++;
      if (!full) begin
        check("w3_wdata", wdata, 32'hC0DE_0000 + idx);
        check("w3_wpull", ch_wpull, 4'b1000);
        idx++;
      end
      tick();
    end
    wfull = 1'b0; write_done = 1'b0;
    #1;
    check("w3_pushes", n, 4);
    check("w3_done", ch_req_done, 4'b1000);
    check("w3_no_push_done", wpush, 0);
    ch_req_valid[3] = 1'b0;
    tick();

    // Done pulses on the grant cycle are ignored: beat alone must not finish
    set_req(3, 1'b0, 32'h3300, 8'd0);
    read_done = 1'b1; write_done = 1'b1;
    tick();
    read_done = 1'b0; write_done = 1'b0; rempty = 1'b0;
    #1;
    check("ign_rvalid", ch_rvalid, 4'b1000);
    tick();
    rempty = 1'b1;
    #1;
    check("ign_wait1", ch_req_done, 0);
    tick();
    check("ign_wait2", ch_req_done, 0);
    read_done = 1'b1;
    tick();
    read_done = 1'b0;
    #1;
    check("ign_done", ch_req_done, 4'b1000);
    ch_req_valid[3] = 1'b0;
    tick();

    // Reset asserted mid-write, then ch0 beats ch2
    set_req(1, 1'b1, 32'h5000, 8'd3);
    tick();
    ch_wdata[1*DW +: DW] = 32'h55;
    #1;
    check("mw_push", wpush, 1);
    tick();
    cpu_rst_n = 1'b0;
    #1;
    check_all_zero("mw_reset_outputs");
    check("mw_reset_wstart", write_start, 0);
    ch_req_valid = '0; ch_req_write = '0;
    set_req(0, 1'b0, 32'h100, 8'd0);
    set_req(2, 1'b0, 32'h200, 8'd0);
    @(negedge cpu_clk) cpu_rst_n = 1'b1;
    run_len0_read(0, 32'h100, 32'h66);
    ch_req_valid = '0;

    // No progress: read never done, FIFO empty
    set_req(0, 1'b0, 32'h7000, 8'd0);
    rempty = 1'b1;
    tick();
    n = 0;
`ifdef DMA_MC_TIMEOUT_EN
    for (int i = 0; i < 1100 && ch_req_done == 0; i++) begin
      if (read_start) n++;
      tick();
    end
    check("tmo_rd_cycles", n, 1024);
    check("tmo_done", ch_req_done, 4'b0001);
    check("tmo_err", ch_req_err, 4'b0001);
    ch_req_valid = '0;
    tick();
`else
    for (int i = 0; i < 200; i++) begin
      if (ch_req_done != 0 || ch_req_err != 0) n++;
      tick();
    end
    check("wait_no_done", n, 0);
    check("wait_still_rd", read_start, 1);
    rempty = 1'b0; read_done = 1'b1;
    tick();
    rempty = 1'b1; read_done = 1'b0;
    #1;
    check("wait_done", ch_req_done, 4'b0001);
    check("wait_err", ch_req_err, 0);
    ch_req_valid = '0;
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
